mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch requester (IF) and data-memory requester (DM, the MEM stage).
- Sequences each access through an issue/wait/respond FSM and returns read data with a one-cycle ack.
- Drives a global stall to the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers while any request is outstanding.
- DM has priority; a starvation counter guarantees IF progress.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- MEM_LATENCY, 2, cycles from the mem_en_o cycle to the cycle in which mem_rdata_i is valid. Must be >=1; 0 is an elaboration error.
- STARVE_LIMIT, 4, consecutive DM grants made while IF was waiting before IF is forced to win. Must be >=1.

Ports:
- clk_i  in  1  clock, all state changes on the rising edge
- rst_i  in  1  synchronous, active-high reset
- if_req_i  in  1  IF read request; held until if_ack_o
- if_addr_i  in  ADDR_W  IF address
- if_rdata_o  out  DATA_W  IF read data; valid while if_ack_o=1
- if_ack_o  out  1  one-cycle IF completion pulse
- dm_req_i  in  1  DM request; held until dm_ack_o
- dm_we_i  in  1  1=write, 0=read
- dm_addr_i  in  ADDR_W  DM address
- dm_wdata_i  in  DATA_W  DM write data
- dm_rdata_o  out  DATA_W  DM read data; valid while dm_ack_o=1
- dm_ack_o  out  1  one-cycle DM completion pulse
- mem_en_o  out  1  memory access strobe, exactly 1 cycle per transaction
- mem_we_o  out  1  memory write enable, qualified by mem_en_o
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en_o
- stall_o  out  1  pipeline stall
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE, streak=0, wait counter=0.
  - All registered outputs become 0: mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, if_ack_o, dm_ack_o, if_rdata_o, dm_rdata_o, busy_o.
  - stall_o is forced 0 while rst_i=1.
- Reset mid-transaction: the transaction is abandoned, no ack is issued, and the late mem_rdata_i is ignored. Requesters re-request after reset.
- States:
  - IDLE: sample requests. If any is pending, latch the grant, address, we and wdata, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (1 cycle): mem_en_o=1; mem_we_o=latched we (0 for IF); mem_addr_o and mem_wdata_o driven from the latches. Go to WAIT with cnt=MEM_LATENCY-1.
  - WAIT (MEM_LATENCY cycles): cnt decrements each cycle. When cnt=0, capture mem_rdata_i into the granted requester's rdata register (reads only) and go to RESP.
  - RESP (1 cycle): the granted requester's ack=1. Go unconditionally to IDLE; the request still asserted this cycle belongs to the acked transaction.
- Latency: request first seen in IDLE at cycle 0 -> ack at cycle MEM_LATENCY+2. The earliest next grant is in IDLE at cycle MEM_LATENCY+3.
- mem_en_o, mem_we_o, if_ack_o and dm_ack_o are 0 outside ISSUE/RESP. mem_addr_o and mem_wdata_o hold their last values.
- Arbitration (IDLE only):
  - Only one requester pending: grant it.
  - Both pending: grant DM unless streak==STARVE_LIMIT, in which case grant IF.
- streak:
  - Any IF grant sets streak=0.
  - A DM grant with if_req_i=1 increments streak, saturating at STARVE_LIMIT.
  - A DM grant with if_req_i=0 sets streak=0.
- DM write:
  - Issued with mem_we_o=1; the ack timing is identical to a read.
  - dm_rdata_o is not updated.
- Read data: if_rdata_o and dm_rdata_o hold the last captured value until the next capture for that requester.
- Stability: the address, we and wdata latched at grant are used; input changes after the grant are ignored.
- Withdrawn request: if a requester drops req before RESP (e.g. an IF flush on a taken branch), the transaction still completes and ack still pulses; the requester ignores it.
- stall_o (combinational) = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o), gated by ~rst_i.
- busy_o = (state != IDLE), registered with the state.

Test Plan:
1. IF read only, MEM_LATENCY=2, if_addr_i=0x10, memory returns 0xDEADBEEF -> mem_en_o=1 only in cycle 1 with mem_addr_o=0x10; if_ack_o=1 only in cycle 4 with if_rdata_o=0xDEADBEEF; stall_o=1 in cycles 0-3 and 0 in cycle 4.
2. DM write to 0x20 with data 0x12345678 -> mem_en_o=mem_we_o=1 for exactly 1 cycle with mem_addr_o=0x20 and mem_wdata_o=0x12345678; dm_ack_o pulses at cycle 4; dm_rdata_o unchanged.
3. IF and DM requesting simultaneously in cycle 0 -> DM is granted first (dm_ack_o at cycle 4); IF is granted in IDLE at cycle 5 (if_ack_o at cycle 9).
4. DM requesting continuously with IF held, STARVE_LIMIT=4 -> exactly 4 DM acks, then an IF ack, then DM resumes; streak returns to 0 after the IF grant.
5. Assert rst_i during WAIT of a DM read -> next cycle: state IDLE, all outputs 0, no dm_ack_o, the late mem_rdata_i does not reach dm_rdata_o; a new request after reset completes normally.
6. Change if_addr_i from 0x10 to 0x40 during WAIT, then drop if_req_i before RESP -> mem_addr_o stays 0x10; if_ack_o still pulses once; the arbiter returns to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbiter sharing one fixed-latency memory between IF and DM requesters
//
// Purpose: serialises instruction-fetch (IF) and data-memory (DM) accesses onto a
// single-ported memory through an IDLE/ISSUE/WAIT/RESP sequence. DM wins ties
// unless IF has been passed over STARVE_LIMIT times in a row. Raises a pipeline
// stall while any request is still waiting for its ack.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   if_req_i/if_addr_i           IF read request and address
//   if_rdata_o/if_ack_o          IF read data and one-cycle completion pulse
//   dm_req_i/dm_we_i             DM request, 1=write 0=read
//   dm_addr_i/dm_wdata_i         DM address and write data
//   dm_rdata_o/dm_ack_o          DM read data and one-cycle completion pulse
//   mem_en_o/mem_we_o            memory strobe (one cycle per access) and write enable
//   mem_addr_o/mem_wdata_o       memory address and write data
//   mem_rdata_i                  memory read data, valid MEM_LATENCY cycles after mem_en_o
//   stall_o                      pipeline stall
//   busy_o                       sequencer not idle
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ack_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_ack_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o,
   output logic              busy_o
);

   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int STK_W = $clog2(STARVE_LIMIT + 1);

   if (MEM_LATENCY < 1) begin : g_bad_latency
      $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
   end
   if (STARVE_LIMIT < 1) begin : g_bad_starve
      $error("mem_port_arbiter: STARVE_LIMIT must be >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [STK_W-1:0]  r_streak;
   logic              r_gnt_dm;
   logic              r_we;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_if_ack;
   logic              r_dm_ack;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_dm_rdata;

   logic              w_any;
   logic              w_gnt_dm;
   logic              w_starved;

   assign w_any     = if_req_i | dm_req_i;
   // IF only overrides DM once it has lost STARVE_LIMIT consecutive contested grants.
   assign w_starved = if_req_i && (r_streak == STK_W'(STARVE_LIMIT));
   assign w_gnt_dm  = dm_req_i & ~w_starved;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_streak    <= '0;
         r_gnt_dm    <= 1'b0;
         r_we        <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_ack    <= 1'b0;
         r_dm_ack    <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
      end else begin
         r_state  <= w_next;
         r_mem_en <= 1'b0;
         r_mem_we <= 1'b0;
         r_if_ack <= 1'b0;
         r_dm_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  // The memory-side address/data registers double as the grant latch,
                  // so later changes on the requester inputs cannot leak in.
                  r_gnt_dm   <= w_gnt_dm;
                  r_we       <= w_gnt_dm & dm_we_i;
                  r_mem_en   <= 1'b1;
                  r_mem_we   <= w_gnt_dm & dm_we_i;
                  r_mem_addr <= w_gnt_dm ? dm_addr_i : if_addr_i;
                  if (w_gnt_dm) begin
                     r_mem_wdata <= dm_wdata_i;
                  end
                  if (!w_gnt_dm || !if_req_i) begin
                     r_streak <= '0;
                  end else if (r_streak != STK_W'(STARVE_LIMIT)) begin
                     r_streak <= r_streak + STK_W'(1);
                  end
               end
            end
            S_ISSUE: begin
               r_cnt <= CNT_W'(MEM_LATENCY - 1);
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_if_ack <= ~r_gnt_dm;
                  r_dm_ack <= r_gnt_dm;
                  if (!r_we) begin
                     if (r_gnt_dm) r_dm_rdata <= mem_rdata_i;
                     else          r_if_rdata <= mem_rdata_i;
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_en_o    = r_mem_en;
   assign mem_we_o    = r_mem_we;
   assign mem_addr_o  = r_mem_addr;
   assign mem_wdata_o = r_mem_wdata;
   assign if_ack_o    = r_if_ack;
   assign dm_ack_o    = r_dm_ack;
   assign if_rdata_o  = r_if_rdata;
   assign dm_rdata_o  = r_dm_rdata;
   assign busy_o      = (r_state != S_IDLE);
   assign stall_o     = ~rst_i & ((if_req_i & ~r_if_ack) | (dm_req_i & ~r_dm_ack));

endmodule
